axil_wr_arbiter: RTL and testbench

- N-to-1 arbiter for the AXI4-Lite write path (AW, W, B) in the VIP test harness.
- Lets several AXI-Lite write masters share one downstream slave port, one transaction at a time.
- Round-robin fairness between masters; full AW/W/B handshake sequencing.
- Read channels are out of scope.

---
 rtl/axil_wr_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_axil_wr_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_wr_arbiter.sv
// N-to-1 arbiter for the AXI4-Lite write path (AW, W, B).
// Serves one write transaction at a time. Masters are chosen round-robin,
// starting from the master after the one that finished most recently.
// A master is only considered once it presents both AW and W.
// Read channels are not handled here.
module axil_wr_arbiter #(
  parameter int NUM_M  = 2,   // 2..8 upstream masters
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32   // 32 or 64
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  // upstream (slave-side) ports, master i occupies slice i
  input  logic [NUM_M-1:0]          s_awvalid,
  output logic [NUM_M-1:0]          s_awready,
  input  logic [NUM_M*ADDR_W-1:0]   s_awaddr,
  input  logic [NUM_M-1:0]          s_wvalid,
  output logic [NUM_M-1:0]          s_wready,
  input  logic [NUM_M*DATA_W-1:0]   s_wdata,
  input  logic [NUM_M*DATA_W/8-1:0] s_wstrb,
  output logic [NUM_M-1:0]          s_bvalid,
  input  logic [NUM_M-1:0]          s_bready,
  output logic [2*NUM_M-1:0]        s_bresp,
  // downstream (master-side) port
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [ADDR_W-1:0]         m_awaddr,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  output logic [DATA_W-1:0]         m_wdata,
  output logic [DATA_W/8-1:0]       m_wstrb,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  input  logic [1:0]                m_bresp,
  // status
  output logic                      busy,
  output logic [2:0]                grant_idx
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [2:0] LAST_RST = 3'(NUM_M - 1);

  // Reject illegal parameter values at elaboration time.
  if (NUM_M < 2 || NUM_M > 8) begin : g_bad_num_m
    $error("axil_wr_arbiter: NUM_M must be in 2..8");
  end
  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $error("axil_wr_arbiter: DATA_W must be 32 or 64");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e     state_q,   state_d;
  logic [2:0] grant_q,   grant_d;
  logic [2:0] last_q,    last_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q,  w_done_d;

  logic [NUM_M-1:0]  req;
  logic [NUM_M-1:0]  grant_oh;
  logic              rr_found;
  logic [2:0]        rr_winner;
  logic              sel_awvalid;
  logic              sel_wvalid;
  logic              sel_bready;
  logic              aw_hs;
  logic              w_hs;

  // A master is eligible only when both its address and data are offered.
  assign req = s_awvalid & s_wvalid;

  // Decode the registered grant index into a one-hot lane select.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no path can leave it unassigned and infer a latch.
    grant_oh = '0;
    for (int i = 0; i < NUM_M; i++) begin
      grant_oh[i] = (grant_q == 3'(i));
    end
  end

  // Round-robin pick: first requester at or after last+1, wrapping.
  // Scanning distances from far to near lets the nearest one win.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    for (int k = NUM_M; k >= 1; k--) begin
      for (int i = 0; i < NUM_M; i++) begin
        if (req[i] && ((int'(last_q) + k) % NUM_M) == i) begin
          rr_found  = 1'b1;
          rr_winner = 3'(i);
        end
      end
    end
  end

  // Route the granted master's payload and handshake inputs downstream.
  always_comb begin
    sel_awvalid = 1'b0;
    sel_wvalid  = 1'b0;
    sel_bready  = 1'b0;
    m_awaddr    = '0;
    m_wdata     = '0;
    m_wstrb     = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (grant_oh[i]) begin
        sel_awvalid = s_awvalid[i];
        sel_wvalid  = s_wvalid[i];
        sel_bready  = s_bready[i];
        m_awaddr    = s_awaddr[i*ADDR_W +: ADDR_W];
        m_wdata     = s_wdata[i*DATA_W +: DATA_W];
        m_wstrb     = s_wstrb[i*STRB_W +: STRB_W];
      end
    end
  end

  // Transaction sequencer: next state plus all handshake outputs.
  // Readies depend only on registered state and downstream readies,
  // never on an upstream valid.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          grant_d = rr_winner;
          state_d = ST_ADDR;
        end
      end

      ST_ADDR: begin
        m_awvalid = sel_awvalid & ~aw_done_q;
        s_awready = grant_oh & {NUM_M{m_awready & ~aw_done_q}};
        m_wvalid  = sel_wvalid & ~w_done_q;
        s_wready  = grant_oh & {NUM_M{m_wready & ~w_done_q}};
        aw_hs     = m_awvalid & m_awready;
        w_hs      = m_wvalid & m_wready;
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        // Both channels done, either earlier or in this very cycle.
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d   = ST_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end

      ST_RESP: begin
        m_bready = sel_bready;
        s_bvalid = grant_oh & {NUM_M{m_bvalid}};
        if (m_bvalid && sel_bready) begin
          last_d  = grant_q;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and bookkeeping registers; reset abandons any transaction.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      last_q    <= LAST_RST;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      // NOTE: registers use non-blocking assignment so every flop samples pre-edge values regardless of statement order.
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Write response code goes to every lane; only the granted lane sees bvalid.
  assign s_bresp   = {NUM_M{m_bresp}};
  assign busy      = (state_q != ST_IDLE);
  assign grant_idx = grant_q;

endmodule

// File: tb/tb_axil_wr_arbiter.sv
// Self-checking bench for axil_wr_arbiter: directed scenarios followed by
// random AXI-Lite traffic, all cross-checked against a transaction model.
module tb_axil_wr_arbiter;

  localparam int NUM_M       = 3;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int STRB_W      = DATA_W / 8;
  localparam int RAND_CYCLES = 4000;

  logic                      aclk = 1'b0;
  logic                      aresetn;
  logic [NUM_M-1:0]          s_awvalid, s_awready, s_wvalid, s_wready;
  logic [NUM_M-1:0]          s_bvalid, s_bready;
  logic [NUM_M*ADDR_W-1:0]   s_awaddr;
  logic [NUM_M*DATA_W-1:0]   s_wdata;
  logic [NUM_M*STRB_W-1:0]   s_wstrb;
  logic [2*NUM_M-1:0]        s_bresp;
  logic                      m_awvalid, m_awready, m_wvalid, m_wready;
  logic                      m_bvalid, m_bready;
  logic [ADDR_W-1:0]         m_awaddr;
  logic [DATA_W-1:0]         m_wdata;
  logic [STRB_W-1:0]         m_wstrb;
  logic [1:0]                m_bresp;
  logic                      busy;
  logic [2:0]                grant_idx;

  always #5 aclk = ~aclk;

  axil_wr_arbiter #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .busy(busy), .grant_idx(grant_idx)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Transaction model: one write in flight, round-robin after the last winner.
  bit md_active, md_resp, md_aw_ok, md_w_ok;
  int md_g, md_last, md_gidx;
  int md_bcnt   [NUM_M];
  int lane_bcnt [NUM_M];

  // Handshakes observed at the most recent sample point.
  logic [NUM_M-1:0] aw_hs_m, w_hs_m, b_hs_m;
  logic             sl_aw_hs, sl_w_hs, sl_b_hs;

  // Random traffic generators.
  logic [NUM_M-1:0] mst_busy, mst_aw_done, mst_w_done;
  bit               sl_aw_got, sl_w_got;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic md_reset();
    md_active = 1'b0;
    md_resp   = 1'b0;
    md_aw_ok  = 1'b0;
    md_w_ok   = 1'b0;
    md_g      = 0;
    md_last   = NUM_M - 1;
    md_gidx   = 0;
  endtask

  // Compare every DUT output with the model, then advance the model
  // with the inputs that will be sampled at the coming clock edge.
  task automatic model_step();
    logic [NUM_M-1:0] oh;
    logic             exp_awv, exp_wv;
    aw_hs_m  = s_awvalid & s_awready;
    w_hs_m   = s_wvalid & s_wready;
    b_hs_m   = s_bvalid & s_bready;
    sl_aw_hs = m_awvalid & m_awready;
    sl_w_hs  = m_wvalid & m_wready;
    sl_b_hs  = m_bvalid & m_bready;
    for (int i = 0; i < NUM_M; i++) if (b_hs_m[i]) lane_bcnt[i]++;

    if (!aresetn) begin
      chk("rst_quiet", 64'({s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready}), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_grant_idx", 64'(grant_idx), 64'd0);
      md_reset();
      return;
    end

    chk("busy", 64'(busy), 64'(md_active));
    chk("grant_idx", 64'(grant_idx), 64'(md_gidx));
    chk("bresp_repl", 64'(s_bresp), 64'({NUM_M{m_bresp}}));

    if (!md_active) begin
      chk("idle_quiet", 64'({s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready}), 64'd0);
      for (int k = 1; k <= NUM_M; k++) begin
        int c;
        c = (md_last + k) % NUM_M;
        if (s_awvalid[c] && s_wvalid[c]) begin
          md_active = 1'b1;
          md_g      = c;
          md_gidx   = c;
          break;
        end
      end
    end else if (!md_resp) begin
      oh       = '0;
      oh[md_g] = 1'b1;
      exp_awv  = s_awvalid[md_g] & ~md_aw_ok;
      exp_wv   = s_wvalid[md_g] & ~md_w_ok;
      chk("addr_m_awvalid", 64'(m_awvalid), 64'(exp_awv));
      chk("addr_m_wvalid", 64'(m_wvalid), 64'(exp_wv));
      chk("addr_s_awready", 64'(s_awready), 64'((m_awready && !md_aw_ok) ? oh : '0));
      chk("addr_s_wready", 64'(s_wready), 64'((m_wready && !md_w_ok) ? oh : '0));
      chk("addr_b_quiet", 64'({m_bready, s_bvalid}), 64'd0);
      chk("addr_m_awaddr", 64'(m_awaddr), 64'(s_awaddr[md_g*ADDR_W +: ADDR_W]));
      chk("addr_m_wdata", 64'(m_wdata), 64'(s_wdata[md_g*DATA_W +: DATA_W]));
      chk("addr_m_wstrb", 64'(m_wstrb), 64'(s_wstrb[md_g*STRB_W +: STRB_W]));
      if (exp_awv && m_awready) md_aw_ok = 1'b1;
      if (exp_wv && m_wready)   md_w_ok  = 1'b1;
      if (md_aw_ok && md_w_ok) begin
        md_resp  = 1'b1;
        md_aw_ok = 1'b0;
        md_w_ok  = 1'b0;
      end
    end else begin
      oh       = '0;
      oh[md_g] = 1'b1;
      chk("resp_aw_w_quiet", 64'({s_awready, s_wready, m_awvalid, m_wvalid}), 64'd0);
      chk("resp_m_bready", 64'(m_bready), 64'(s_bready[md_g]));
      chk("resp_s_bvalid", 64'(s_bvalid), 64'(m_bvalid ? oh : '0));
      if (m_bvalid && s_bready[md_g]) begin
        md_bcnt[md_g]++;
        md_last   = md_g;
        md_active = 1'b0;
        md_resp   = 1'b0;
      end
    end
  endtask

  task automatic half();
    @(negedge aclk);
    model_step();
  endtask

  task automatic adv();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs();
    s_awvalid = '0; s_wvalid = '0; s_bready = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
  endtask

  task automatic set_payload(input int i, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
    s_awaddr[i*ADDR_W +: ADDR_W] = a;
    s_wdata[i*DATA_W +: DATA_W]  = d;
    s_wstrb[i*STRB_W +: STRB_W]  = s;
  endtask

  // One cycle of random, protocol-respecting masters and slave.
  task automatic rand_drive(input bit allow_new);
    for (int i = 0; i < NUM_M; i++) begin
      if (aw_hs_m[i]) begin s_awvalid[i] = 1'b0; mst_aw_done[i] = 1'b1; end
      if (w_hs_m[i])  begin s_wvalid[i]  = 1'b0; mst_w_done[i]  = 1'b1; end
      if (b_hs_m[i])  mst_busy[i] = 1'b0;
      if (!mst_busy[i] && allow_new && $urandom_range(2) == 0) begin
        mst_busy[i]    = 1'b1;
        mst_aw_done[i] = 1'b0;
        mst_w_done[i]  = 1'b0;
        set_payload(i, ADDR_W'($urandom), DATA_W'($urandom), STRB_W'($urandom));
      end
      if (mst_busy[i] && !mst_aw_done[i] && !s_awvalid[i] && $urandom_range(1) == 1) s_awvalid[i] = 1'b1;
      if (mst_busy[i] && !mst_w_done[i] && !s_wvalid[i] && $urandom_range(1) == 1)   s_wvalid[i]  = 1'b1;
      s_bready[i] = ($urandom_range(3) != 0);
    end
    if (sl_b_hs) begin m_bvalid = 1'b0; sl_aw_got = 1'b0; sl_w_got = 1'b0; end
    if (sl_aw_hs) sl_aw_got = 1'b1;
    if (sl_w_hs)  sl_w_got  = 1'b1;
    if (sl_aw_got && sl_w_got && !m_bvalid && $urandom_range(1) == 1) begin
      m_bvalid = 1'b1;
      m_bresp  = 2'($urandom_range(3));
    end
    m_awready = ($urandom_range(1) == 1);
    m_wready  = ($urandom_range(1) == 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int grants[$];
    int exp_order[4];
    int bc[NUM_M];
    bit prev_busy;
    bit drained;

    md_reset();
    for (int i = 0; i < NUM_M; i++) begin md_bcnt[i] = 0; lane_bcnt[i] = 0; end
    mst_busy = '0; mst_aw_done = '0; mst_w_done = '0;
    sl_aw_got = 1'b0; sl_w_got = 1'b0;
    s_awaddr = '0; s_wdata = '0; s_wstrb = '0;
    clear_inputs();
    aresetn = 1'b0;
    half(); adv();
    half(); adv();
    aresetn = 1'b1;

    // Single request from master 0, slave takes AW and W together.
    set_payload(0, 32'h10, 32'hDEADBEEF, 4'hF);
    s_awvalid = 3'b001; s_wvalid = 3'b001; m_awready = 1'b1; m_wready = 1'b1;
    half(); chk("t1_idle_busy", 64'(busy), 64'd0); adv();
    half();
    chk("t1_m_awvalid", 64'(m_awvalid), 64'd1);
    chk("t1_m_awaddr", 64'(m_awaddr), 64'h10);
    chk("t1_m_wdata", 64'(m_wdata), 64'hDEADBEEF);
    chk("t1_m_wstrb", 64'(m_wstrb), 64'hF);
    adv();
    s_awvalid = '0; s_wvalid = '0; m_awready = 1'b0; m_wready = 1'b0;
    m_bvalid = 1'b1; m_bresp = 2'b00; s_bready = 3'b001;
    half();
    chk("t1_s_bvalid", 64'(s_bvalid), 64'b001);
    chk("t1_s_bresp0", 64'(s_bresp[1:0]), 64'b00);
    chk("t1_busy_resp", 64'(busy), 64'd1);
    adv();
    m_bvalid = 1'b0; s_bready = '0;
    half(); chk("t1_busy_after_b", 64'(busy), 64'd0); adv();

    // Contention: masters 0 and 1 request continuously after a reset.
    aresetn = 1'b0;
    half(); adv();
    aresetn = 1'b1;
    set_payload(0, 32'h100, 32'h0000_0A0A, 4'h3);
    set_payload(1, 32'h200, 32'h0000_0B0B, 4'hC);
    s_awvalid = 3'b011; s_wvalid = 3'b011; m_awready = 1'b1; m_wready = 1'b1;
    m_bvalid = 1'b1; m_bresp = 2'b00; s_bready = '1;
    prev_busy = 1'b0;
    for (int i = 0; i < NUM_M; i++) bc[i] = 0;
    for (int c = 0; c < 12; c++) begin
      half();
      if (busy && !prev_busy) grants.push_back(int'(grant_idx));
      prev_busy = busy;
      for (int i = 0; i < NUM_M; i++) if (s_bvalid[i] && s_bready[i]) bc[i]++;
      adv();
    end
    clear_inputs();
    half(); adv();
    exp_order = '{0, 1, 0, 1};
    chk("t2_num_grants", 64'(grants.size()), 64'd4);
    for (int k = 0; k < grants.size() && k < 4; k++) chk("t2_grant_order", 64'(grants[k]), 64'(exp_order[k]));
    chk("t2_b_count_m0", 64'(bc[0]), 64'd2);
    chk("t2_b_count_m1", 64'(bc[1]), 64'd2);

    // Split handshake: AW at ADDR cycle 1, W at ADDR cycle 4.
    set_payload(0, 32'h3000, 32'h1234_5678, 4'h5);
    s_awvalid = 3'b001; s_wvalid = 3'b001;
    half(); adv();
    m_awready = 1'b1;
    half();
    chk("t3_c1_m_awvalid", 64'(m_awvalid), 64'd1);
    chk("t3_c1_s_awready", 64'(s_awready), 64'b001);
    adv();
    for (int c = 2; c <= 3; c++) begin
      half();
      chk("t3_aw_masked", 64'(m_awvalid), 64'd0);
      chk("t3_awready_masked", 64'(s_awready), 64'd0);
      chk("t3_still_addr", 64'({busy, m_wvalid}), 64'b11);
      adv();
    end
    m_awready = 1'b0; m_wready = 1'b1;
    half(); chk("t3_c4_s_wready", 64'(s_wready), 64'b001); adv();
    s_awvalid = '0; s_wvalid = '0; m_wready = 1'b0;
    m_bvalid = 1'b1; s_bready = 3'b001;
    half();
    chk("t3_resp_bvalid", 64'(s_bvalid), 64'b001);
    chk("t3_resp_bready", 64'(m_bready), 64'd1);
    adv();
    clear_inputs();
    half(); adv();

    // Partial request: master 1 offers AW only, master 0 offers both.
    set_payload(1, 32'h4400, 32'hCAFE_0001, 4'hF);
    s_awvalid = 3'b011; s_wvalid = 3'b001;
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; s_bready = '1;
    half(); adv();
    half();
    chk("t5_grant_m0", 64'(grant_idx), 64'd0);
    chk("t5_awready_m0", 64'(s_awready), 64'b001);
    adv();
    s_awvalid = 3'b010; s_wvalid = 3'b000;
    half(); chk("t5_b_m0", 64'(s_bvalid), 64'b001); adv();
    half(); adv();
    half(); chk("t5_no_partial_grant", 64'(busy), 64'd0); adv();
    s_wvalid = 3'b010;
    half(); adv();
    half();
    chk("t5_grant_m1", 64'(grant_idx), 64'd1);
    chk("t5_m1_awaddr", 64'(m_awaddr), 64'h4400);
    adv();
    s_awvalid = '0; s_wvalid = '0;
    half(); chk("t5_b_m1", 64'(s_bvalid), 64'b010); adv();
    clear_inputs();
    half(); adv();

    // Early B: slave signals SLVERR while the arbiter is still in ADDR.
    set_payload(1, 32'h5500, 32'h0BAD_F00D, 4'h9);
    s_awvalid = 3'b010; s_wvalid = 3'b010;
    m_bvalid = 1'b1; m_bresp = 2'b10; s_bready = 3'b010;
    half(); chk("t4_idle_bready", 64'(m_bready), 64'd0); adv();
    half(); chk("t4_addr1_bready", 64'(m_bready), 64'd0); adv();
    m_awready = 1'b1; m_wready = 1'b1;
    half();
    chk("t4_addr2_bready", 64'(m_bready), 64'd0);
    chk("t4_addr2_bvalid", 64'(s_bvalid), 64'd0);
    adv();
    s_awvalid = '0; s_wvalid = '0; m_awready = 1'b0; m_wready = 1'b0;
    half();
    chk("t4_resp_bready", 64'(m_bready), 64'd1);
    chk("t4_resp_bvalid", 64'(s_bvalid), 64'b010);
    chk("t4_lane1_bresp", 64'(s_bresp[3:2]), 64'b10);
    adv();
    clear_inputs();
    half(); adv();

    // Reset while a B response is pending on master 0.
    set_payload(0, 32'h6600, 32'h7777_8888, 4'hF);
    s_awvalid = 3'b001; s_wvalid = 3'b001; m_awready = 1'b1; m_wready = 1'b1;
    half(); adv();
    half(); adv();
    s_awvalid = '0; s_wvalid = '0; m_awready = 1'b0; m_wready = 1'b0;
    m_bvalid = 1'b1; s_bready = '0;
    half();
    chk("t6_bvalid_before_rst", 64'(s_bvalid), 64'b001);
    #2;
    aresetn = 1'b0;
    #1;
    chk("t6_async_quiet", 64'({s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready}), 64'd0);
    chk("t6_async_busy", 64'(busy), 64'd0);
    chk("t6_async_grant_idx", 64'(grant_idx), 64'd0);
    md_reset();
    adv();
    half(); adv();
    aresetn = 1'b1;
    m_bvalid = 1'b0;
    s_awvalid = '1; s_wvalid = '1;
    half(); adv();
    half(); chk("t6_first_grant_m0", 64'(grant_idx), 64'd0); adv();
    m_awready = 1'b1; m_wready = 1'b1;
    half(); adv();
    s_awvalid = '0; s_wvalid = '0; m_awready = 1'b0; m_wready = 1'b0;
    m_bvalid = 1'b1; s_bready = '1;
    half(); adv();
    clear_inputs();
    half(); adv();

    // Random traffic, checked every cycle by the model.
    aw_hs_m = '0; w_hs_m = '0; b_hs_m = '0;
    sl_aw_hs = 1'b0; sl_w_hs = 1'b0; sl_b_hs = 1'b0;
    for (int c = 0; c < RAND_CYCLES; c++) begin
      rand_drive(1'b1);
      half();
      adv();
    end
    drained = 1'b0;
    for (int c = 0; c < 400 && !drained; c++) begin
      rand_drive(1'b0);
      half();
      adv();
      drained = (mst_busy == '0) && !m_bvalid && !busy;
    end
    chk("rand_drain_done", 64'(drained), 64'd1);
    for (int i = 0; i < NUM_M; i++) chk("rand_b_count", 64'(lane_bcnt[i]), 64'(md_bcnt[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
